// File: rtl/uart_tx_arbiter.sv
// Line-locking arbiter: several byte-stream requesters share one UART transmitter.
// A requester holds the transmitter until it sends EolChar or stays silent for TimeoutCycles.
module uart_tx_arbiter #(
    parameter int         NumReq        = 4,
    parameter int         TimeoutCycles = 1024,
    parameter logic [7:0] EolChar       = 8'h0A
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_valid_i,
    input  logic [NumReq*8-1:0]       req_data_i,
    output logic [NumReq-1:0]         req_ready_o,
    output logic                      uart_valid_o,
    output logic [7:0]                uart_data_o,
    input  logic                      uart_ready_i,
    output logic [$clog2(NumReq)-1:0] owner_o,
    output logic                      locked_o
);

    localparam int OwnW = $clog2(NumReq);

    // Handshakes: a byte moves on any stream when valid && ready in the same cycle;
    // the requester keeps its byte stable while valid is high and unacknowledged.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [OwnW-1:0]   owner_q, owner_d;
    logic [OwnW-1:0]   rr_q, rr_d;
    logic [31:0]       idle_q, idle_d;

    logic [OwnW:0]     scan_sum;
    logic [OwnW-1:0]   scan_idx;
    logic [OwnW-1:0]   pick_idx;
    logic              pick_found;
    logic              owner_valid;
    logic [7:0]        owner_data;
    logic              owner_hs;
    logic              eol_hit;
    logic              timeout_hit;
    logic [OwnW-1:0]   owner_next;

    // Round-robin scan: first valid requester at or above rr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            scan_sum = {1'b0, rr_q} + (OwnW+1)'(k);
            if (scan_sum >= (OwnW+1)'(NumReq)) begin
                scan_sum = scan_sum - (OwnW+1)'(NumReq);
            end
            scan_idx = scan_sum[OwnW-1:0];
            if (!pick_found && req_valid_i[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign owner_valid = req_valid_i[owner_q];
    assign owner_data  = req_data_i[{owner_q, 3'b000} +: 8];
    assign owner_hs    = (state_q == LOCKED) && owner_valid && uart_ready_i;
    assign eol_hit     = owner_hs && (owner_data == EolChar);
    // Timeout only counts silent cycles, so it can never coincide with an EOL handshake.
    assign timeout_hit = (state_q == LOCKED) && !owner_valid
                         && (idle_q == 32'(TimeoutCycles - 1));
    assign owner_next  = (owner_q == OwnW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    owner_d = pick_idx;
                    idle_d  = '0;
                end
            end
            LOCKED: begin
                if (eol_hit || timeout_hit) begin
                    state_d = IDLE;
                    rr_d    = owner_next;
                    idle_d  = '0;
                end else if (owner_hs) begin
                    idle_d = '0;
                end else if (!owner_valid) begin
                    idle_d = idle_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_valid_o = 1'b0;
        uart_data_o  = 8'h00;
        req_ready_o  = '0;
        if (state_q == LOCKED) begin
            uart_valid_o         = owner_valid;
            uart_data_o          = owner_valid ? owner_data : 8'h00;
            req_ready_o[owner_q] = uart_ready_i;
        end
    end

    assign owner_o  = owner_q;
    assign locked_o = (state_q == LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a line-lock reference model checked
// every cycle, and directed line scenarios with hand-written expected byte logs.
module tb_uart_tx_arbiter;

    localparam int         N   = 4;
    localparam int         TO  = 16;
    localparam logic [7:0] EOL = 8'h0A;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*8-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             uart_valid;
    logic [7:0]       uart_data;
    logic             uart_ready = 1'b0;
    logic [1:0]       owner;
    logic             locked;

    uart_tx_arbiter #(.NumReq(N), .TimeoutCycles(TO), .EolChar(EOL)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .uart_valid_o(uart_valid),
        .uart_data_o (uart_data),
        .uart_ready_i(uart_ready),
        .owner_o     (owner),
        .locked_o    (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tx_q[N][$];
    logic [15:0] acc_q[$];
    logic [15:0] exp_q[$];
    int          hs_cyc_q[$];
    int          cyc = 0;
    logic [N-1:0] hs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (tx_q[i].size() > 0);
            req_data[8*i +: 8] = (tx_q[i].size() > 0) ? tx_q[i][0] : 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Requester driver: pops a byte once its handshake was seen in the previous cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
            end
            apply();
        end
    end

    // Reference model: who holds the line, where the round-robin resumes, how long silent.
    bit m_locked;
    int m_owner, m_rr, m_idle;

    function automatic int first_from(input int p);
        for (int k = 0; k < N; k++) begin
            if (req_valid[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked <= 1'b0;
            m_owner  <= 0;
            m_rr     <= 0;
            m_idle   <= 0;
        end else if (!m_locked) begin
            if (|req_valid) begin
                m_locked <= 1'b1;
                m_owner  <= first_from(m_rr);
                m_idle   <= 0;
            end
        end else if (req_valid[m_owner] && uart_ready) begin
            if (req_data[8*m_owner +: 8] == EOL) begin
                m_locked <= 1'b0;
                m_rr     <= (m_owner + 1) % N;
            end
            m_idle <= 0;
        end else if (!req_valid[m_owner]) begin
            if (m_idle + 1 == TO) begin
                m_locked <= 1'b0;
                m_rr     <= (m_owner + 1) % N;
                m_idle   <= 0;
            end else begin
                m_idle <= m_idle + 1;
            end
        end
    end

    // Per-cycle compare against the model, plus a log of every transmitted byte.
    always @(negedge clk) begin
        logic       ev;
        logic [7:0] ed;
        logic [N-1:0] er;
        if (rst_n) begin
            ev = m_locked && req_valid[m_owner];
            ed = ev ? req_data[8*m_owner +: 8] : 8'h00;
            er = (m_locked && uart_ready) ? (N'(1) << m_owner) : '0;
            check("cyc_uart_valid", 32'(uart_valid), 32'(ev));
            check("cyc_uart_data", 32'(uart_data), 32'(ed));
            check("cyc_req_ready", 32'(req_ready), 32'(er));
            check("cyc_locked", 32'(locked), 32'(m_locked));
            check("cyc_owner", 32'(owner), 32'(m_owner));
            if (uart_valid && uart_ready) begin
                acc_q.push_back({6'b0, owner, uart_data});
                hs_cyc_q.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        uart_ready = 1'b0;
        for (int i = 0; i < N; i++) tx_q[i].delete();
        apply();
        repeat (2) step();
        rst_n = 1'b1;
        acc_q.delete();
        exp_q.delete();
        hs_cyc_q.delete();
        step();
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(acc_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            check({name, "_byte"}, 32'(acc_q[i]), 32'(exp_q[i]));
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic send_line(input int r, input logic [7:0] a, input logic [7:0] b);
        tx_q[r].push_back(a);
        tx_q[r].push_back(b);
    endtask

    initial begin
        int n_idle;
        bit stable;

        // Reset state, then "hi\n" from req1; rr then points at 2.
        do_reset();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_valid", 32'(uart_valid), 32'd0);
        uart_ready = 1'b1;
        tx_q[1].push_back(8'h68);
        send_line(1, 8'h69, 8'h0A);
        apply();
        check("s1_idle_valid", 32'(uart_valid), 32'd0);
        check("s1_idle_ready", 32'(req_ready), 32'd0);
        step();
        check("s1_b0", 32'(uart_data), 32'h68);
        check("s1_owner", 32'(owner), 32'd1);
        step();
        check("s1_b1", 32'(uart_data), 32'h69);
        step();
        check("s1_b2", 32'(uart_data), 32'h0A);
        step();
        check("s1_released", 32'(locked), 32'd0);
        send_line(0, 8'h41, 8'h0A);
        send_line(2, 8'h41, 8'h0A);
        apply();
        repeat (8) step();
        exp_q = '{16'h0168, 16'h0169, 16'h010A, 16'h0241, 16'h020A, 16'h0041, 16'h000A};
        check_log("s1_log");

        // req0 and req2 together after reset: whole lines, req0 first.
        do_reset();
        uart_ready = 1'b1;
        send_line(0, 8'h41, 8'h0A);
        send_line(2, 8'h41, 8'h0A);
        apply();
        repeat (8) step();
        exp_q = '{16'h0041, 16'h000A, 16'h0241, 16'h020A};
        check_log("s2_log");

        // Timeout: req0 sends 'x' then goes silent; req3 waits.
        do_reset();
        uart_ready = 1'b1;
        tx_q[0].push_back(8'h78);
        send_line(3, 8'h5A, 8'h0A);
        apply();
        step();
        check("s3_x", 32'(uart_data), 32'h78);
        step();
        n_idle = 0;
        while (locked && n_idle < 40) begin
            n_idle++;
            step();
        end
        check("s3_idle_cycles", 32'(n_idle), 32'd16);
        check("s3_released", 32'(locked), 32'd0);
        step();
        check("s3_next_owner", 32'(owner), 32'd3);
        check("s3_next_locked", 32'(locked), 32'd1);
        repeat (4) step();
        exp_q = '{16'h0078, 16'h035A, 16'h030A};
        check_log("s3_log");

        // Long transmitter stall with owner valid: no timeout, byte held.
        do_reset();
        uart_ready = 1'b0;
        send_line(1, 8'h51, 8'h0A);
        apply();
        step();
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (uart_data !== 8'h51 || locked !== 1'b1 || req_ready !== 4'b0000) stable = 1'b0;
            step();
        end
        check("s4_stall_stable", 32'(stable), 32'd1);
        uart_ready = 1'b1;
        step();
        check("s4_after_ready", 32'(uart_data), 32'h0A);
        repeat (3) step();
        exp_q = '{16'h0151, 16'h010A};
        check_log("s4_log");

        // Reset mid-line from req2: immediate zero outputs, no replay, fresh grant from 0.
        do_reset();
        uart_ready = 1'b1;
        tx_q[2].push_back(8'h61);
        send_line(2, 8'h62, 8'h63);
        tx_q[2].push_back(8'h0A);
        apply();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("s5_rst_valid", 32'(uart_valid), 32'd0);
        check("s5_rst_data", 32'(uart_data), 32'd0);
        check("s5_rst_ready", 32'(req_ready), 32'd0);
        check("s5_rst_locked", 32'(locked), 32'd0);
        check("s5_rst_owner", 32'(owner), 32'd0);
        for (int i = 0; i < N; i++) tx_q[i].delete();
        send_line(1, 8'h6B, 8'h0A);
        send_line(3, 8'h6D, 8'h0A);
        apply();
        #2;
        rst_n = 1'b1;
        step();
        check("s5_owner_after", 32'(owner), 32'd1);
        check("s5_locked_after", 32'(locked), 32'd1);
        repeat (8) step();
        exp_q = '{16'h0261, 16'h016B, 16'h010A, 16'h036D, 16'h030A};
        check_log("s5_log");

        // All four send single EOL bytes: strict rotation, one idle cycle between grants.
        do_reset();
        uart_ready = 1'b1;
        for (int i = 0; i < N; i++) send_line(i, 8'h0A, 8'h0A);
        apply();
        repeat (20) step();
        check("s6_gap_count", 32'(hs_cyc_q.size()), 32'd8);
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            check("s6_gap", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd2);
        end
        exp_q = '{16'h000A, 16'h010A, 16'h020A, 16'h030A,
                  16'h000A, 16'h010A, 16'h020A, 16'h030A};
        check_log("s6_log");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001: The block SHALL have parameter NumReq, default 4, meaning the number of byte-stream requesters (2..16).
REQ-002: The block SHALL have parameter TimeoutCycles, default 1024, meaning the idle cycles after which an incomplete line loses the lock (>=2).
REQ-003: The block SHALL have parameter EolChar, default 8'h0A, meaning the byte that ends a line and releases the lock.
REQ-004: The block SHALL have port clk_i  input  1  clock; one clock only, all logic on its rising edge.
REQ-005: The block SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006: The block SHALL have port req_valid_i  input  NumReq  per-requester byte valid.
REQ-007: The block SHALL have port req_data_i  input  NumReq*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008: The block SHALL have port req_ready_o  output  NumReq  per-requester byte accepted.
REQ-009: The block SHALL have port uart_valid_o  output  1  byte valid towards the shared UART transmitter.
REQ-010: The block SHALL have port uart_data_o  output  8  byte towards the transmitter.
REQ-011: The block SHALL have port uart_ready_i  input  1  transmitter accepts the byte.
REQ-012: The block SHALL have port owner_o  output  $clog2(NumReq)  index of the current lock owner.
REQ-013: The block SHALL have port locked_o  output  1  lock held (state LOCKED).

Function
REQ-014: A handshake on any stream SHALL be valid && ready in the same cycle; a requester's data SHALL be assumed stable while its valid is high and unacknowledged.
REQ-015: The FSM SHALL have two states, IDLE and LOCKED.
REQ-016: In IDLE, uart_valid_o and all req_ready_o SHALL be 0.
REQ-017: In IDLE with any req_valid_i high, the block SHALL select the first valid index at or above rr_ptr, wrapping modulo NumReq; next cycle it SHALL be LOCKED with owner_o = that index.
REQ-018: Grant latency SHALL be exactly one cycle: a request seen in IDLE in cycle n can be forwarded in cycle n+1 at the earliest.
REQ-019: In LOCKED, uart_valid_o SHALL equal req_valid_i[owner], uart_data_o SHALL equal the owner's byte, req_ready_o[owner] SHALL equal uart_ready_i (combinational), and all other req_ready_o SHALL be 0.
REQ-020: In LOCKED, uart_data_o SHALL be 8'h00 when req_valid_i[owner] is 0.
REQ-021: A handshake in LOCKED whose byte equals EolChar SHALL move the FSM to IDLE and set rr_ptr = (owner+1) mod NumReq.
REQ-022: A 32-bit idle counter SHALL clear on entering LOCKED and on every owner handshake.
REQ-023: The idle counter SHALL increment only in LOCKED cycles with req_valid_i[owner] = 0; cycles stalled by uart_ready_i = 0 SHALL not count.
REQ-024: When the idle counter equals TimeoutCycles-1 and increments, the FSM SHALL move to IDLE with rr_ptr = (owner+1) mod NumReq.
REQ-025: EOL release and timeout SHALL be mutually exclusive by construction, since timeout requires the owner's valid to be low.
REQ-026: A requester whose valid drops in IDLE before being granted SHALL not be granted.
REQ-027: Non-owner requesters SHALL see req_ready_o = 0 for the whole LOCKED period, whatever their valid.

Reset
REQ-028: On rst_ni low, the FSM SHALL go to IDLE immediately (asynchronously), with rr_ptr = 0, owner_o = 0, locked_o = 0, idle counter = 0, uart_valid_o = 0, uart_data_o = 0 and req_ready_o = 0.
REQ-029: A line in progress when reset asserts SHALL be abandoned, with no replay after reset.
REQ-030: After reset deassertion, the first grant SHALL use rr_ptr = 0.

Verification
REQ-031: Scenario: req1 sends 'h','i',8'h0A with uart_ready_i = 1 -> one IDLE cycle, then 3 consecutive bytes 68,69,0A on uart_data_o, then locked_o = 0 and the next rr_ptr = 2.
REQ-032: Scenario: after reset, req0 and req2 are valid together, each sending "A\n" -> req0's line completes first, then req2's, with no interleaving of bytes.
REQ-033: Scenario: TimeoutCycles = 16, owner sends 'x' then drops valid -> locked_o falls after exactly 16 idle cycles, and a pending req3 is granted next.
REQ-034: Scenario: owner valid high, uart_ready_i = 0 for 100 cycles -> no timeout, uart_data_o held stable, and the byte is accepted once ready rises.
REQ-035: Scenario: rst_ni pulsed low in the middle of a line from req2 -> all outputs read 0 at once, and the first grant after reset goes to the lowest valid index.
REQ-036: Scenario: all 4 requesters continuously send single 8'h0A bytes -> grant order 0,1,2,3,0,1, with one IDLE cycle between grants.
